// File: rtl/rf_pkg.sv
// Shared defaults for the decode-stage register file and its pending-write scoreboard.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write tracker: set on issue, cleared on writeback, exposes busy per read port.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int  NREGS  = NREGS_DEF,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ISSUE_EN,
  input  logic [AW-1:0] ISSUE_RD,
  input  logic          WE3,
  input  logic [AW-1:0] A3,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  output logic          BUSY1,
  output logic          BUSY2
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             wb_hit1;
  logic             wb_hit2;

  // A new producer issued in the same cycle its predecessor writes back keeps the register pending.
  always_comb begin
    pend_nxt           = pend;
    pend_nxt[REG_ZERO] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (ISSUE_EN && (ISSUE_RD == AW'(r))) begin
        pend_nxt[r] = 1'b1;
      end else if (WE3 && (A3 == AW'(r))) begin
        pend_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign wb_hit1 = (BYPASS != 0) && WE3 && (A3 == A1);
  assign wb_hit2 = (BYPASS != 0) && WE3 && (A3 == A2);

  assign BUSY1 = !RST && pend[A1] && !wb_hit1;
  assign BUSY2 = !RST && pend[A2] && !wb_hit2;

endmodule

// File: rtl/register_file_sb.sv
// Decode-stage register file: two combinational read ports, one write port, optional
// write-to-read bypass, and a pending-write scoreboard for the hazard unit.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREGS  = NREGS_DEF,
  parameter int  BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISSUE_EN,
  input  logic [AW-1:0]   ISSUE_RD
);

  logic [XLEN-1:0] regs [NREGS];
  logic            byp1;
  logic            byp2;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WE3 && (A3 != AW'(REG_ZERO))) begin
      regs[A3] <= WD3;
    end
  end

  assign byp1 = (BYPASS != 0) && WE3 && (A3 == A1);
  assign byp2 = (BYPASS != 0) && WE3 && (A3 == A2);

  // Reset and x0 take priority over the bypass so a stray WD3 never leaks out.
  assign RD1 = (RST || (A1 == AW'(REG_ZERO))) ? '0 : (byp1 ? WD3 : regs[A1]);
  assign RD2 = (RST || (A2 == AW'(REG_ZERO))) ? '0 : (byp2 ? WD3 : regs[A2]);

  rf_scoreboard #(
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .ISSUE_EN (ISSUE_EN),
    .ISSUE_RD (ISSUE_RD),
    .WE3      (WE3),
    .A3       (A3),
    .A1       (A1),
    .A2       (A2),
    .BUSY1    (BUSY1),
    .BUSY2    (BUSY2)
  );

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench driving a bypass and a non-bypass register file from shared stimulus.
module tb_register_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   a1, a2, a3, issue_rd;
  logic            we3, issue_en;
  logic [XLEN-1:0] wd3;

  logic [XLEN-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic            busy1_b, busy2_b, busy1_n, busy2_n;

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_byp (
    .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
    .BUSY1(busy1_b), .BUSY2(busy2_b), .WE3(we3), .A3(a3), .WD3(wd3),
    .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd)
  );

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_nobyp (
    .CLK(clk), .RST(rst), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
    .BUSY1(busy1_n), .BUSY2(busy2_n), .WE3(we3), .A3(a3), .WD3(wd3),
    .ISSUE_EN(issue_en), .ISSUE_RD(issue_rd)
  );

  typedef struct {
    string           name;
    int              dut;
    int              cyc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            b1;
    logic            b2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation tagged for the current cycle, away from the edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [XLEN-1:0] r1, r2;
      logic            b1, b2;
      e = q.pop_front();
      if (e.dut == 0) begin
        r1 = rd1_b; r2 = rd2_b; b1 = busy1_b; b2 = busy2_b;
      end else begin
        r1 = rd1_n; r2 = rd2_n; b1 = busy1_n; b2 = busy2_n;
      end
      n_total++;
      if (e.cyc == cyc && r1 === e.rd1 && r2 === e.rd2 && b1 === e.b1 && b2 === e.b2) begin
        n_pass++;
      end else begin
        $display("FAIL %s dut=%0s cyc=%0d/%0d got rd1=%h rd2=%h b1=%b b2=%b want rd1=%h rd2=%h b1=%b b2=%b",
                 e.name, (e.dut == 0) ? "bypass" : "nobypass", cyc, e.cyc,
                 r1, r2, b1, b2, e.rd1, e.rd2, e.b1, e.b2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; a3 = '0; wd3 = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  // which: 0 = bypass DUT, 1 = non-bypass DUT, 2 = both with the same expectation
  task automatic expect_out(input string name, input int which,
                            input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                            input logic b1, input logic b2);
    exp_t e;
    e.name = name; e.cyc = cyc; e.rd1 = rd1; e.rd2 = rd2; e.b1 = b1; e.b2 = b2;
    if (which != 1) begin e.dut = 0; q.push_back(e); end
    if (which != 0) begin e.dut = 1; q.push_back(e); end
  endtask

  initial begin
    rst = 1'b1; idle(); a1 = '0; a2 = '0;

    // Reset state; a write presented during reset must not leak through the bypass.
    step();
    a1 = 5; a2 = 0; we3 = 1'b1; a3 = 5; wd3 = 32'hFFFF_FFFF;
    issue_en = 1'b1; issue_rd = 5;
    expect_out("reset_state", 2, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0; idle(); a1 = 5;
    expect_out("write_in_reset_ignored", 2, 32'h0, 32'h0, 1'b0, 1'b0);

    // x5 = DEADBEEF with x5 pending, then reset mid-run.
    step();
    we3 = 1'b1; a3 = 5; wd3 = 32'hDEAD_BEEF; issue_en = 1'b1; issue_rd = 5; a1 = 5;
    expect_out("x5_write_byp", 0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
    expect_out("x5_write_nobyp", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle(); a1 = 5;
    expect_out("x5_stored_pending", 2, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    expect_out("reset_midrun", 2, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    expect_out("after_reset", 2, 32'h0, 32'h0, 1'b0, 1'b0);

    // x0 is never written and never pending.
    step();
    we3 = 1'b1; a3 = 0; wd3 = 32'hFFFF_FFFF; issue_en = 1'b1; issue_rd = 0; a1 = 0; a2 = 0;
    expect_out("x0_same_cycle", 2, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("x0_next", 2, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    expect_out("x0_later", 2, 32'h0, 32'h0, 1'b0, 1'b0);

    // Bypass: write x7 while both ports read x7.
    step();
    we3 = 1'b1; a3 = 7; wd3 = 32'h1234_5678; a1 = 7; a2 = 7;
    expect_out("x7_bypass", 0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    expect_out("x7_nobypass_old", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("x7_stored", 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);

    // Scoreboard: issue x3 at cycle 0, writeback at cycle 3.
    step();
    issue_en = 1'b1; issue_rd = 3; a1 = 3; a2 = 0;
    expect_out("x3_c0", 2, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle(); a2 = 3;
    expect_out("x3_c1", 2, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    expect_out("x3_c2", 2, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    we3 = 1'b1; a3 = 3; wd3 = 32'h0000_00A5; a2 = 7;
    expect_out("x3_c3_byp", 0, 32'h0000_00A5, 32'h1234_5678, 1'b0, 1'b0);
    expect_out("x3_c3_nobyp", 1, 32'h0, 32'h1234_5678, 1'b1, 1'b0);
    step();
    idle();
    expect_out("x3_c4", 2, 32'h0000_00A5, 32'h1234_5678, 1'b0, 1'b0);

    // Simultaneous set and clear on x9: data updates, pending wins.
    step();
    issue_en = 1'b1; issue_rd = 9; we3 = 1'b1; a3 = 9; wd3 = 32'h55; a1 = 9; a2 = 9;
    expect_out("x9_edge_byp", 0, 32'h55, 32'h55, 1'b0, 1'b0);
    expect_out("x9_edge_nobyp", 1, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    idle();
    expect_out("x9_after", 2, 32'h55, 32'h55, 1'b1, 1'b1);
    step();
    a2 = 3;
    expect_out("x9_hold", 2, 32'h55, 32'h0000_00A5, 1'b1, 1'b0);

    step();
    step();
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain left=%0d want=0", q.size());
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout cyc=%0d want finish", cyc);
      $fatal(1, "timeout");
    end
  end

endmodule
